// File: rtl/rv_inst_encoder.sv
// ---------------------------------------------------------------------------
// rv_inst_encoder
//
// Streaming RV32I instruction encoder. The inverse of the core's decoder: it
// takes instruction descriptors (format kind, opcode, funct fields, register
// indices, full 32-bit immediate) and packs each one into a 32-bit RV32I word.
// The words go out on an instruction-memory write stream whose address starts
// at base_addr and advances by 4 for every word written. It is used to fill
// instruction memory before the core leaves reset.
//
// Optional feature macro: ENCODER_IMM_CHECK_EN
//   defined   -> immediates that do not fit their format are rejected
//   undefined -> out-of-range immediate bits are silently truncated; only an
//                invalid kind (6/7) is rejected
//
// Parameters
//   ADDR_W  width of the write address and base address (default 32)
//   CNT_W   width of the descriptor count and error counter (default 16)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             pulse; latches base_addr/count and begins a run (IDLE only)
//   base_addr, count  first byte address and number of descriptors in the run
//   in_valid/in_ready descriptor handshake
//   in_kind           0=R 1=I 2=S 3=B 4=U 5=J, 6/7 invalid
//   in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm
//                     descriptor fields (in_imm is the unshifted byte offset)
//   out_valid/out_ready write-stream handshake
//   out_addr, out_data address and encoded word held in the output register
//   busy              high while the run is in progress (state != IDLE)
//   done              one-cycle pulse at the end of a run
//   err, err_cnt      sticky reject flag and saturating reject count for the run
//   state_dbg         current FSM state (IDLE=0, RUN=1, DRAIN=2)
//
// Handshake rule (both streams): a transfer happens on a rising clk edge where
// valid && ready are both high. A valid source keeps its payload stable until
// that transfer. in_ready is combinational on out_ready so that accept and
// output handshakes may land in the same cycle (one word per cycle).
// ---------------------------------------------------------------------------
module rv_inst_encoder #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] KIND_R = 3'd0;
  localparam logic [2:0] KIND_I = 3'd1;
  localparam logic [2:0] KIND_S = 3'd2;
  localparam logic [2:0] KIND_B = 3'd3;
  localparam logic [2:0] KIND_U = 3'd4;
  localparam logic [2:0] KIND_J = 3'd5;

  state_t             state;
  logic [ADDR_W-1:0]  addr;       // address the next written word will use
  logic [CNT_W-1:0]   remaining;  // descriptors still to accept this run

  logic               accept;
  logic               out_fire;
  logic               kind_ok;
  logic               imm_ok;
  logic               desc_ok;
  logic [31:0]        enc_word;

  // -------------------------------------------------------------------------
  // Format packing. Immediate bits that do not belong to a format are simply
  // not selected, which is the truncation behaviour of the default build.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = 32'd0;
    case (kind)
      KIND_R: w = {f7, rs2, rs1, f3, rd, op};
      KIND_I: w = {imm[11:0], rs1, f3, rd, op};
      KIND_S: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      KIND_B: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      KIND_U: w = {imm[31:12], rd, op};
      KIND_J: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

`ifdef ENCODER_IMM_CHECK_EN
  // An immediate fits when every bit above the format's top bit equals that
  // top bit (i.e. it is the sign extension of the encodable field). Branch
  // and jump offsets must also be halfword aligned; U needs zero low bits.
  function automatic logic imm_fits(input logic [2:0] kind, input logic [31:0] imm);
    logic ok;
    ok = 1'b1;
    case (kind)
      KIND_I, KIND_S: ok = (imm[31:11] == {21{imm[11]}});
      KIND_B:         ok = !imm[0] && (imm[31:12] == {20{imm[12]}});
      KIND_J:         ok = !imm[0] && (imm[31:20] == {12{imm[20]}});
      KIND_U:         ok = (imm[11:0] == 12'd0);
      default:        ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign imm_ok = imm_fits(in_kind, in_imm);
`else
  assign imm_ok = 1'b1;
`endif

  assign kind_ok  = (in_kind <= KIND_J);
  assign desc_ok  = kind_ok && imm_ok;
  assign enc_word = encode(in_kind, in_opcode, in_funct3, in_funct7,
                           in_rd, in_rs1, in_rs2, in_imm);

  // Accept only while descriptors remain and the output register is free or
  // is being emptied in this same cycle.
  assign in_ready  = (state == RUN) && (remaining != '0) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // -------------------------------------------------------------------------
  // Control FSM and output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      done <= 1'b0;

      // Emptying the register; a same-cycle load below overrides this.
      if (out_fire) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= count;
            err       <= 1'b0;
            err_cnt   <= '0;
            // An empty run completes immediately without visiting RUN.
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end

        RUN: begin
          if (accept) begin
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= DRAIN;
            end
            if (desc_ok) begin
              out_valid <= 1'b1;
              out_data  <= enc_word;
              out_addr  <= addr;
              addr      <= addr + ADDR_W'(4);
            end else begin
              // Rejected descriptors are consumed but leave no word and no
              // address gap behind them.
              err <= 1'b1;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
            end
          end
        end

        DRAIN: begin
          // Finish once the last word (if any) has left the register.
          if (!out_valid || out_ready) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
module tb_rv_inst_encoder;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  count;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  err_cnt;
  logic [1:0]        state_dbg;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int last_waits = 0;

  // Scoreboard: {addr, data} of every word the sink accepted vs expected.
  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];

  rv_inst_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .busy(busy), .done(done), .err(err),
    .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back({out_addr, out_data});
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic run_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    base_addr = b;
    count     = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic drive_desc(input logic [2:0] kind, input logic [6:0] op,
                            input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    in_kind = kind; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
  endtask

  // Present one descriptor and hold it until accepted (bounded).
  task automatic send(input logic [2:0] kind, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    bit got;
    got = 1'b0;
    drive_desc(kind, op, f3, f7, rd, rs1, rs2, imm);
    in_valid   = 1'b1;
    last_waits = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
      if (!got) last_waits++;
    end
    in_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b after 50 cycles, required 1", in_ready);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done: no done pulse within 50 cycles, required one", name);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_addr !== '0)    begin errors++; $display("FAIL reset_out_addr: got %h want 0", out_addr); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
    checks++; if (err_cnt !== '0)     begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [63:0] e, o;
    out_ready = 1'b1;
    run_start(32'h100, 16'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b want 1", busy); end
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    checks++; if (out_valid !== 1'b1)        begin errors++; $display("FAIL single_out_valid: got %0b want 1", out_valid); end
    checks++; if (out_addr !== 32'h100)      begin errors++; $display("FAIL single_out_addr: got %h want 00000100", out_addr); end
    checks++; if (out_data !== 32'h00500093) begin errors++; $display("FAIL single_out_data: got %h want 00500093", out_data); end
    checks++; if (done !== 1'b0)             begin errors++; $display("FAIL single_done_early: got %0b want 0", done); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %0b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %0b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %0b want 0", done); end
    exp_q.push_back({32'h100, 32'h00500093});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_words: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL single_word: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [63:0] e, o;
    int dc;
    out_ready = 1'b1;
    dc = done_cnt;
    run_start(32'h200, 16'd3);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    checks++; if (last_waits != 0) begin errors++; $display("FAIL b2b_s_wait: waited %0d cycles want 0", last_waits); end
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
    checks++; if (last_waits != 0) begin errors++; $display("FAIL b2b_b_wait: waited %0d cycles want 0", last_waits); end
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    checks++; if (last_waits != 0) begin errors++; $display("FAIL b2b_j_wait: waited %0d cycles want 0", last_waits); end
    wait_done("b2b");
    checks++; if (done_cnt != dc + 1) begin errors++; $display("FAIL b2b_done_count: got %0d pulses want 1", done_cnt - dc); end
    exp_q.push_back({32'h200, 32'h0020A423});
    exp_q.push_back({32'h204, 32'hFE000EE3});
    exp_q.push_back({32'h208, 32'h001000EF});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_words: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_word: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [63:0] e, o;
    out_ready = 1'b0;
    run_start(32'h300, 16'd2);
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
    drive_desc(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0)         begin errors++; $display("FAIL bp_in_ready: cycle %0d got %0b want 0", i, in_ready); end
      checks++; if (out_data !== 32'h402081B3) begin errors++; $display("FAIL bp_out_data: cycle %0d got %h want 402081b3", i, out_data); end
      checks++; if (out_addr !== 32'h300)      begin errors++; $display("FAIL bp_out_addr: cycle %0d got %h want 00000300", i, out_addr); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready: got %0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_data !== 32'h123452B7) begin errors++; $display("FAIL bp_second_data: got %h want 123452b7", out_data); end
    checks++; if (out_addr !== 32'h304)      begin errors++; $display("FAIL bp_second_addr: got %h want 00000304", out_addr); end
    wait_done("bp");
    exp_q.push_back({32'h300, 32'h402081B3});
    exp_q.push_back({32'h304, 32'h123452B7});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL bp_words: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL bp_word: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_imm_range();
    logic [63:0] e, o;
    logic        want_err;
    logic [CNT_W-1:0] want_cnt;
    out_ready = 1'b1;
    run_start(32'h400, 16'd2);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1);
    wait_done("imm");
`ifdef ENCODER_IMM_CHECK_EN
    want_err = 1'b1; want_cnt = 16'd1;
    exp_q.push_back({32'h400, 32'h00100113});
`else
    want_err = 1'b0; want_cnt = 16'd0;
    exp_q.push_back({32'h400, 32'h80000093});
    exp_q.push_back({32'h404, 32'h00100113});
`endif
    checks++; if (err !== want_err)     begin errors++; $display("FAIL imm_err: got %0b want %0b", err, want_err); end
    checks++; if (err_cnt !== want_cnt) begin errors++; $display("FAIL imm_err_cnt: got %0d want %0d", err_cnt, want_cnt); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL imm_words: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL imm_word: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_kind();
    logic [63:0] e, o;
    out_ready = 1'b1;
    run_start(32'h500, 16'd3);
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL kind_err_clear: got %0b want 0", err); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL kind_cnt_clear: got %0d want 0", err_cnt); end
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    send(3'd7, 7'h13, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'd0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1);
    wait_done("kind");
    checks++; if (err !== 1'b1)      begin errors++; $display("FAIL kind_err: got %0b want 1", err); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL kind_err_cnt: got %0d want 1", err_cnt); end
    exp_q.push_back({32'h500, 32'h00500093});
    exp_q.push_back({32'h504, 32'h00100113});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL kind_words: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL kind_word: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap_and_empty();
    logic [63:0] e, o;
    out_ready = 1'b1;
    run_start(32'hFFFF_FFFC, 16'd2);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1);
    wait_done("wrap");
    exp_q.push_back({32'hFFFF_FFFC, 32'h00500093});
    exp_q.push_back({32'h0000_0000, 32'h00100113});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wrap_words: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_word: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    // Empty run: done on the very next cycle, never busy.
    run_start(32'h800, 16'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL empty_done: got %0b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %0b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_done_width: got %0b want 0", done); end
  endtask

  task automatic test_reset_midrun();
    logic [63:0] e, o;
    int dc;
    out_ready = 1'b0;
    run_start(32'h600, 16'd3);
    send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: out_valid got %0b want 1", out_valid); end
    checks++; if (err_cnt !== 16'd1)  begin errors++; $display("FAIL mid_err_cnt_pre: got %0d want 1", err_cnt); end
    dc = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_busy: got %0b want 0", busy); end
    checks++; if (err_cnt !== '0)     begin errors++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL mid_err: got %0b want 0", err); end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt != dc)     begin errors++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt - dc); end
    checks++; if (obs_q.size() != 0)  begin errors++; $display("FAIL mid_no_word: got %0d words want 0", obs_q.size()); end
    obs_q.delete();
    run_start(32'h700, 16'd1);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1);
    wait_done("mid_restart");
    exp_q.push_back({32'h700, 32'h00100113});
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mid_restart_words: got %0d words want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_restart_word: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    drive_desc(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_imm_range();
    test_bad_kind();
    test_wrap_and_empty();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
